// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
//   Pipeline MEM-stage request bus and data-memory strobe bus used by
//   dmem_arbiter.
//
//   Pipeline side : p_rd, p_wr, p_addr, p_wdata (request), pipe_stall (hold)
//   Memory side   : mem_rd, mem_wr, mem_addr, mem_wdata
//
//   Modports
//     master : the requester/observer (pipeline plus memory model). It drives
//              p_* and sees mem_* and pipe_stall.
//     slave  : the arbiter. It receives p_* and drives mem_* and pipe_stall.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) ();

  logic                  p_rd;
  logic                  p_wr;
  logic [ADDR_WIDTH-1:0] p_addr;
  logic [DATA_WIDTH-1:0] p_wdata;

  logic                  mem_rd;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  pipe_stall;

  modport master (
    output p_rd, p_wr, p_addr, p_wdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, pipe_stall
  );

  modport slave (
    input  p_rd, p_wr, p_addr, p_wdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata, pipe_stall
  );

endinterface : dmem_arbiter_if

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares one data-memory port between the pipeline MEM stage and an
//   external button-driven loader. The pipeline normally owns the port; a
//   loader press is captured, waits in PEND while the pipeline is busy (for
//   at most STARVE_LIMIT+1 granted cycles), then takes the port for exactly
//   one EXT_WR cycle, stalling the pipeline only if it was requesting.
//
//   Ports
//     clk          : clock, all state on rising edge
//     rst          : synchronous active-high reset
//     bus          : dmem_arbiter_if.slave (p_* in, mem_* / pipe_stall out)
//     ext_set      : loader strobe (level, from a button)
//     ext_val      : loader write value (zero-extended to DATA_WIDTH)
//     ext_num      : loader write address (zero-extended to ADDR_WIDTH)
//     ext_busy     : a loader write is pending or in progress
//     ext_done     : one-cycle pulse in the cycle after the loader write
//     ext_overrun  : sticky, a press arrived while busy and was dropped
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_arbiter_if.slave         bus,
  input  logic                  ext_set,
  input  logic [2:0]            ext_val,
  input  logic [1:0]            ext_num,
  output logic                  ext_busy,
  output logic                  ext_done,
  output logic                  ext_overrun
);

  // Age must be able to hold STARVE_LIMIT itself; keep at least one bit.
  localparam int AGE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    EXT_WR = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [AGE_W-1:0]      age_q, age_d;
  logic [ADDR_WIDTH-1:0] ext_addr_q;
  logic [DATA_WIDTH-1:0] ext_data_q;
  logic                  ext_prev;

  logic                  strobe_edge;
  logic                  capture;
  logic                  done_d;
  logic                  overrun_d;
  logic                  pipe_req;

  // ext_prev resets to 1 so a button held through reset is not seen as a press.
  assign strobe_edge = ext_set & ~ext_prev;
  assign pipe_req    = bus.p_rd | bus.p_wr;
  assign ext_busy    = (state_q != IDLE);

  // Next-state and datapath steering.
  // NOTE: every signal driven here gets its default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d        = state_q;
    age_d          = age_q;
    capture        = 1'b0;
    done_d         = 1'b0;
    overrun_d      = ext_overrun;

    // Pipeline owns the port unless the loader write is happening now.
    bus.mem_rd     = bus.p_rd;
    bus.mem_wr     = bus.p_wr;
    bus.mem_addr   = bus.p_addr;
    bus.mem_wdata  = bus.p_wdata;
    bus.pipe_stall = 1'b0;

    case (state_q)
      IDLE: begin
        if (strobe_edge) begin
          state_d = PEND;
          age_d   = '0;
          capture = 1'b1;
        end
      end

      PEND: begin
        // Go as soon as the pipeline leaves the port free, or force it once
        // the pipeline has had its maximum run of granted cycles.
        if (!pipe_req || age_q == AGE_MAX) begin
          state_d = EXT_WR;
        end else begin
          age_d = age_q + AGE_W'(1);
        end
      end

      EXT_WR: begin
        state_d        = IDLE;
        age_d          = '0;
        done_d         = 1'b1;
        // Both pipeline strobes are blocked, even a conflicting rd+wr pair.
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b1;
        bus.mem_addr   = ext_addr_q;
        bus.mem_wdata  = ext_data_q;
        bus.pipe_stall = pipe_req;
      end

      default: begin
        state_d = IDLE;
        age_d   = '0;
      end
    endcase

    // A press while busy is dropped; the captured write stays untouched.
    if (strobe_edge && state_q != IDLE) begin
      overrun_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset is synchronous, so it sits inside the
  // clocked block and no asynchronous path to the flops exists.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      age_q       <= '0;
      ext_addr_q  <= '0;
      ext_data_q  <= '0;
      ext_done    <= 1'b0;
      ext_overrun <= 1'b0;
      ext_prev    <= 1'b1;
    end else begin
      state_q     <= state_d;
      age_q       <= age_d;
      ext_done    <= done_d;
      ext_overrun <= overrun_d;
      ext_prev    <= ext_set;
      if (capture) begin
        ext_addr_q <= ADDR_WIDTH'(ext_num);
        ext_data_q <= DATA_WIDTH'(ext_val);
      end
    end
  end

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Scoreboard bench for dmem_arbiter. The stimulus process applies one set
//   of inputs per cycle, runs a transaction-level reference model and pushes
//   the expected outputs of that cycle into exp_q (and, in a completion
//   cycle, the expected loader write into exp_wr_q). A separate monitor pops
//   and compares on every falling edge. Directed scenarios from the block's
//   verification list are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int LIMIT = 3;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          stall;
    logic          busy;
    logic          done;
    logic          ovr;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       ext_set;
  logic [2:0] ext_val;
  logic [1:0] ext_num;
  logic       ext_busy;
  logic       ext_done;
  logic       ext_overrun;

  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

  dmem_arbiter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bif),
    .ext_set    (ext_set),
    .ext_val    (ext_val),
    .ext_num    (ext_num),
    .ext_busy   (ext_busy),
    .ext_done   (ext_done),
    .ext_overrun(ext_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr_seen = 0;

  exp_t exp_q[$];
  wr_t  exp_wr_q[$];

  // Stimulus for the current cycle.
  logic          s_rst = 1'b1;
  logic          s_prd = 1'b0;
  logic          s_pwr = 1'b0;
  logic [AW-1:0] s_paddr = '0;
  logic [DW-1:0] s_pdata = '0;
  logic          s_set = 1'b0;
  logic [2:0]    s_val = '0;
  logic [1:0]    s_num = '0;

  // Reference model: one outstanding loader transaction at most.
  bit            m_valid   = 1'b0; // model state is known (after first reset)
  bit            m_prev    = 1'b1; // button level seen last cycle
  bit            m_waiting = 1'b0; // accepted, not yet written
  bit            m_writing = 1'b0; // this cycle is the loader write
  int            m_granted = 0;    // pipeline cycles granted while waiting
  bit            m_done    = 1'b0;
  bit            m_ovr     = 1'b0;
  logic [AW-1:0] m_addr    = '0;
  logic [DW-1:0] m_data    = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cycle();
    exp_t e;
    bit   edge_seen;
    bit   was_busy;
    bit   req;
    req = s_prd || s_pwr;
    if (m_valid) begin
      e.rd    = m_writing ? 1'b0   : s_prd;
      e.wr    = m_writing ? 1'b1   : s_pwr;
      e.addr  = m_writing ? m_addr : s_paddr;
      e.wdata = m_writing ? m_data : s_pdata;
      e.stall = m_writing && req;
      e.busy  = m_waiting || m_writing;
      e.done  = m_done;
      e.ovr   = m_ovr;
      exp_q.push_back(e);
      if (m_done) exp_wr_q.push_back('{addr: m_addr, data: m_data});
    end
    if (s_rst) begin
      m_valid = 1'b1; m_prev = 1'b1; m_waiting = 1'b0; m_writing = 1'b0;
      m_granted = 0; m_done = 1'b0; m_ovr = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      edge_seen = s_set && !m_prev;
      was_busy  = m_waiting || m_writing;
      m_done    = m_writing;
      if (m_writing) begin
        m_writing = 1'b0;
      end else if (m_waiting) begin
        if (!req || m_granted == LIMIT) begin
          m_waiting = 1'b0;
          m_writing = 1'b1;
        end else begin
          m_granted++;
        end
      end
      if (edge_seen) begin
        if (was_busy) begin
          m_ovr = 1'b1;
        end else begin
          m_waiting = 1'b1;
          m_granted = 0;
          m_addr    = AW'(s_num);
          m_data    = DW'(s_val);
        end
      end
      m_prev = s_set;
    end
  endtask

  // Apply s_* just after the rising edge, then advance the model.
  task automatic step();
    @(posedge clk);
    #1;
    rst         = s_rst;
    bif.p_rd    = s_prd;
    bif.p_wr    = s_pwr;
    bif.p_addr  = s_paddr;
    bif.p_wdata = s_pdata;
    ext_set     = s_set;
    ext_val     = s_val;
    ext_num     = s_num;
    model_cycle();
  endtask

  // Move to the falling edge of the current cycle for directed checks.
  task automatic to_neg();
    #4;
  endtask

  task automatic quiet();
    s_rst = 1'b0; s_prd = 1'b0; s_pwr = 1'b0; s_set = 1'b0;
    s_paddr = '0; s_pdata = '0;
  endtask

  // Monitor: compares every cycle, independent of the stimulus ordering.
  initial begin : monitor
    exp_t          e;
    wr_t           w;
    logic          prev_rd = 1'b0;
    logic          prev_wr = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mem_rd",      32'(bif.mem_rd),     32'(e.rd));
        check("mem_wr",      32'(bif.mem_wr),     32'(e.wr));
        check("mem_addr",    32'(bif.mem_addr),   32'(e.addr));
        check("mem_wdata",   32'(bif.mem_wdata),  32'(e.wdata));
        check("pipe_stall",  32'(bif.pipe_stall), 32'(e.stall));
        check("ext_busy",    32'(ext_busy),       32'(e.busy));
        check("ext_done",    32'(ext_done),       32'(e.done));
        check("ext_overrun", 32'(ext_overrun),    32'(e.ovr));
      end
      if (ext_done === 1'b1) begin
        if (exp_wr_q.size() == 0) begin
          check("ext_write_unexpected", 32'(ext_done), 32'd0);
        end else begin
          w = exp_wr_q.pop_front();
          n_wr_seen++;
          check("ext_write_wr",   32'(prev_wr),   32'd1);
          check("ext_write_rd",   32'(prev_rd),   32'd0);
          check("ext_write_addr", 32'(prev_addr), 32'(w.addr));
          check("ext_write_data", 32'(prev_data), 32'(w.data));
        end
      end
      prev_rd   = bif.mem_rd;
      prev_wr   = bif.mem_wr;
      prev_addr = bif.mem_addr;
      prev_data = bif.mem_wdata;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1; ext_set = 1'b0; ext_val = '0; ext_num = '0;
    bif.p_rd = 1'b0; bif.p_wr = 1'b0; bif.p_addr = '0; bif.p_wdata = '0;

    // Reset, then idle.
    quiet(); s_rst = 1'b1;
    step(); step();
    s_rst = 1'b0;
    step(); to_neg();
    check("reset_busy",  32'(ext_busy),       32'd0);
    check("reset_stall", 32'(bif.pipe_stall), 32'd0);

    // Idle pipeline: press in cycle 0 writes 0x05 at 0x02 in cycle 2.
    quiet(); s_num = 2'd2; s_val = 3'd5; s_set = 1'b1;
    step(); to_neg();                                       // cycle 0
    check("lat_c0_busy", 32'(ext_busy), 32'd0);
    s_set = 1'b0;
    step(); to_neg();                                       // cycle 1
    check("lat_c1_busy", 32'(ext_busy), 32'd1);
    check("lat_c1_wr",   32'(bif.mem_wr), 32'd0);
    step(); to_neg();                                       // cycle 2
    check("lat_c2_wr",    32'(bif.mem_wr),    32'd1);
    check("lat_c2_addr",  32'(bif.mem_addr),  32'h02);
    check("lat_c2_wdata", 32'(bif.mem_wdata), 32'h05);
    check("lat_c2_done",  32'(ext_done),      32'd0);
    step(); to_neg();                                       // cycle 3
    check("lat_c3_done", 32'(ext_done), 32'd1);
    step(); to_neg();                                       // cycle 4
    check("lat_c4_done", 32'(ext_done), 32'd0);

    // Starvation: pipeline reads continuously; press in cycle 0.
    quiet(); s_prd = 1'b1; s_paddr = 8'h40; s_num = 2'd1; s_val = 3'd6; s_set = 1'b1;
    step();                                                 // cycle 0
    s_set = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step(); to_neg();
      check("starve_pend_busy",  32'(ext_busy),       32'd1);
      check("starve_pend_stall", 32'(bif.pipe_stall), 32'd0);
      check("starve_pend_rd",    32'(bif.mem_rd),     32'd1);
    end
    step(); to_neg();                                       // cycle 5
    check("starve_c5_stall", 32'(bif.pipe_stall), 32'd1);
    check("starve_c5_wr",    32'(bif.mem_wr),     32'd1);
    check("starve_c5_rd",    32'(bif.mem_rd),     32'd0);
    step(); to_neg();                                       // cycle 6
    check("starve_c6_stall", 32'(bif.pipe_stall), 32'd0);

    // Second press while PEND is dropped; first value still written.
    quiet(); s_pwr = 1'b1; s_paddr = 8'h33; s_pdata = 8'hA5;
    s_num = 2'd3; s_val = 3'd3; s_set = 1'b1;
    step();
    s_set = 1'b0; step();
    s_val = 3'd7; s_set = 1'b1; step();                     // edge while PEND
    s_set = 1'b0; s_pwr = 1'b0;
    step(); step(); step(); to_neg();
    check("overrun_set", 32'(ext_overrun), 32'd1);
    step(); step(); to_neg();
    check("overrun_sticky", 32'(ext_overrun), 32'd1);

    // Button held through reset: no capture until released and re-pressed.
    quiet(); s_rst = 1'b1; s_set = 1'b1;
    step(); step();
    s_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(); to_neg();
      check("held_no_capture", 32'(ext_busy), 32'd0);
    end
    check("overrun_cleared", 32'(ext_overrun), 32'd0);
    s_set = 1'b0; step();
    s_set = 1'b1; s_num = 2'd1; s_val = 3'd4; step();
    s_set = 1'b0; step(); to_neg();
    check("repress_busy", 32'(ext_busy), 32'd1);
    step(); step();

    // Reset in the PEND cycle abandons the write.
    quiet(); s_num = 2'd2; s_val = 3'd1; s_set = 1'b1;
    step();
    s_set = 1'b0; s_rst = 1'b1; step();                     // PEND cycle
    s_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(); to_neg();
      check("rst_pend_wr",   32'(bif.mem_wr), 32'd0);
      check("rst_pend_busy", 32'(ext_busy),   32'd0);
      check("rst_pend_done", 32'(ext_done),   32'd0);
    end

    // Press in the ext_done cycle is accepted normally.
    quiet(); s_num = 2'd0; s_val = 3'd2; s_set = 1'b1;
    step();                                                 // cycle 0
    s_set = 1'b0; step(); step();                           // cycles 1, 2
    s_set = 1'b1; s_num = 2'd3; s_val = 3'd6;
    step(); to_neg();                                       // cycle 3
    check("back2back_done", 32'(ext_done), 32'd1);
    s_set = 1'b0; step();                                   // cycle 4
    step(); to_neg();                                       // cycle 5
    check("back2back_wr",    32'(bif.mem_wr),    32'd1);
    check("back2back_addr",  32'(bif.mem_addr),  32'h03);
    check("back2back_wdata", 32'(bif.mem_wdata), 32'h06);
    check("back2back_ovr",   32'(ext_overrun),   32'd0);
    step(); step();

    // Randomized traffic with bursts of heavy pipeline load.
    quiet();
    for (int c = 0; c < 3000; c++) begin
      int load;
      load    = ((c / 200) % 2 == 0) ? 9 : 4;
      s_rst   = ($urandom_range(0, 199) == 0);
      s_prd   = ($urandom_range(0, 9) < load);
      s_pwr   = ($urandom_range(0, 9) < load / 2);
      s_paddr = AW'($urandom);
      s_pdata = DW'($urandom);
      if ($urandom_range(0, 3) == 0) s_set = ~s_set;
      s_val   = 3'($urandom);
      s_num   = 2'($urandom);
      step();
    end

    // Drain so any outstanding loader write completes.
    quiet();
    for (int c = 0; c < 10; c++) step();
    to_neg();
    #1;
    check("exp_queue_drained",   32'(exp_q.size()),    32'd0);
    check("write_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("writes_observed",     32'(n_wr_seen > 20),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dmem_arbiter

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data memory word width.
REQ-002 Parameter ADDR_WIDTH, default 8: data memory address width.
REQ-003 Parameter STARVE_LIMIT, default 3: maximum consecutive pipeline-granted cycles while an external write waits.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 p_rd  input  1: pipeline MEM-stage read request.
REQ-007 p_wr  input  1: pipeline MEM-stage write request.
REQ-008 p_addr  input  ADDR_WIDTH: pipeline address.
REQ-009 p_wdata  input  DATA_WIDTH: pipeline write data.
REQ-010 ext_set  input  1: external loader strobe, level input from a button.
REQ-011 ext_val  input  3: external write value.
REQ-012 ext_num  input  2: external write address.
REQ-013 mem_rd  output  1: read strobe to data memory.
REQ-014 mem_wr  output  1: write strobe to data memory.
REQ-015 mem_addr  output  ADDR_WIDTH: memory address.
REQ-016 mem_wdata  output  DATA_WIDTH: memory write data.
REQ-017 pipe_stall  output  1: pipeline must hold its MEM-stage request.
REQ-018 ext_busy  output  1: external request pending or in progress.
REQ-019 ext_done  output  1: one-cycle pulse after an external write completes.
REQ-020 ext_overrun  output  1: sticky flag, set when an external strobe is dropped.

Function
REQ-021 The block SHALL rising-edge-detect ext_set against a registered copy, ext_prev.
REQ-022 FSM states: IDLE, PEND, EXT_WR. Registers: ext_addr_q, ext_data_q, age counter (saturating, clog2(STARVE_LIMIT+1) bits).
REQ-023 IDLE: on edge -> PEND; capture ext_num zero-extended to ADDR_WIDTH and ext_val zero-extended to DATA_WIDTH; age <= 0.
REQ-024 PEND: if p_rd|p_wr is 0, or age == STARVE_LIMIT -> EXT_WR; else age <= age+1 and stay in PEND.
REQ-025 EXT_WR: -> IDLE unconditionally; age <= 0; ext_done <= 1 for exactly the next cycle.
REQ-026 In IDLE and PEND, mem_rd/mem_wr/mem_addr/mem_wdata SHALL combinationally equal p_rd/p_wr/p_addr/p_wdata, and pipe_stall = 0.
REQ-027 In EXT_WR: mem_wr = 1, mem_rd = 0, mem_addr = ext_addr_q, mem_wdata = ext_data_q, pipe_stall = p_rd|p_wr.
REQ-028 ext_busy SHALL be 1 exactly when the state is not IDLE.
REQ-029 A strobe edge detected in PEND or EXT_WR SHALL be discarded, SHALL leave ext_addr_q/ext_data_q unchanged, and SHALL set ext_overrun.
REQ-030 A strobe edge in the cycle after EXT_WR (state IDLE, ext_done high) SHALL be accepted normally.
REQ-031 Latency: an edge sampled in cycle N gives state PEND in N+1. With no pipeline request, the write occurs in N+2 and ext_done is high in N+3.
REQ-032 Starvation bound: at most STARVE_LIMIT+1 pipeline-granted PEND cycles precede EXT_WR, and the pipeline is stalled at most 1 cycle per external write.
REQ-033 If p_rd and p_wr are both 1, both SHALL be forwarded unchanged (the block does not resolve the conflict); both are blocked in EXT_WR.

Reset
REQ-034 When rst = 1 at a clock edge: state <= IDLE, age <= 0, ext_addr_q <= 0, ext_data_q <= 0, ext_done <= 0, ext_overrun <= 0, ext_prev <= 1.
REQ-035 Because ext_prev resets to 1, a strobe held high through reset SHALL NOT produce a capture.
REQ-036 Reset during PEND or EXT_WR SHALL abandon the pending write; no mem_wr from the external path occurs in the cycle after reset.
REQ-037 After reset: pipe_stall = 0 and ext_busy = 0; mem_* follow p_* combinationally.

Verification
REQ-038 Idle pipeline, ext_num=2, ext_val=5, ext_set pulsed high in cycle 0 -> mem_wr=1, mem_addr=0x02, mem_wdata=0x05 in cycle 2; ext_done=1 in cycle 3 only.
REQ-039 p_rd=1 held continuously, STARVE_LIMIT=3, strobe edge in cycle 0 -> PEND for cycles 1-4, EXT_WR in cycle 5 with pipe_stall=1, pipe_stall=0 from cycle 6.
REQ-040 Second edge while PEND (ext_val=7) -> ext_overrun=1 and stays 1; written data remains the first value; ext_overrun clears only on rst.
REQ-041 ext_set held high across rst deassertion -> no capture and ext_busy=0; release then re-press -> normal capture.
REQ-042 rst asserted in the PEND cycle -> no external mem_wr follows; all outputs at reset values.
REQ-043 Edge in the cycle ext_done=1 -> accepted; write in 2 cycles; ext_overrun remains 0.
